// File: rtl/led_band_frame_loader.sv
// rtl/led_band_frame_loader.sv - scatters an HPS word stream into per-band frame memories and times the buffer swap
module led_band_frame_loader #(
  parameter int NB_BANDS       = 4,
  parameter int W_DATA_WIDTH   = 128,
  parameter int WORDS_PER_BAND = 768,
  parameter int ADDR_WIDTH     = $clog2(WORDS_PER_BAND),
  parameter int WRITE_GAP      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [W_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    turn_tick,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  output logic [W_DATA_WIDTH-1:0] w_data,
  output logic [NB_BANDS-1:0]     write,
  output logic                    new_frame,
  output logic                    busy,
  output logic                    err_restart,
  output logic [7:0]              missed_ticks
);

  localparam int BAND_W = (NB_BANDS > 1) ? $clog2(NB_BANDS) : 1;
  localparam int GAP_W  = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS_PER_BAND - 1);
  localparam logic [BAND_W-1:0]     LAST_BAND = BAND_W'(NB_BANDS - 1);
  localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(WRITE_GAP);
  localparam logic [NB_BANDS-1:0]   BAND0_BIT = NB_BANDS'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BAND_W-1:0]       band_q, band_d;
  logic [ADDR_WIDTH-1:0]   word_q, word_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    turn_tick_q;
  logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
  logic [W_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB_BANDS-1:0]     write_q, write_d;
  logic                    new_frame_q, new_frame_d;
  logic                    err_restart_q, err_restart_d;
  logic [7:0]              missed_q, missed_d;

  logic tick_edge;
  logic ready_c;
  logic accept;

  assign tick_edge = turn_tick && !turn_tick_q;

  // State register and all registered outputs; the tick history reloads from the live
  // input during reset so a tick already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    turn_tick_q <= turn_tick;
    if (rst) begin
      state_q       <= S_IDLE;
      band_q        <= '0;
      word_q        <= '0;
      gap_q         <= '0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      write_q       <= '0;
      new_frame_q   <= 1'b0;
      err_restart_q <= 1'b0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      band_q        <= band_d;
      word_q        <= word_d;
      gap_q         <= gap_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      write_q       <= write_d;
      new_frame_q   <= new_frame_d;
      err_restart_q <= err_restart_d;
      missed_q      <= missed_d;
    end
  end

  // Next-state logic: band-major scatter of accepted words, restart handling and
  // swap alignment to the next tick rising edge.
  always_comb begin
    state_d       = state_q;
    band_d        = band_q;
    word_d        = word_q;
    gap_d         = gap_q;
    w_addr_d      = w_addr_q;
    w_data_d      = w_data_q;
    write_d       = '0;
    new_frame_d   = 1'b0;
    err_restart_d = 1'b0;
    missed_d      = missed_q;
    ready_c       = 1'b0;
    accept        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_LOAD;
          band_d  = '0;
          word_d  = '0;
          gap_d   = '0;
        end
      end

      S_LOAD: begin
        // A restart request blocks acceptance in the same cycle so the word it
        // would have consumed is not written at a stale address.
        ready_c = !frame_start && (gap_q == '0);
        accept  = ready_c && s_valid;

        // A tick during loading cannot swap; it is only recorded.
        if (tick_edge && (missed_q != 8'hFF)) begin
          missed_d = missed_q + 8'd1;
        end

        if (frame_start) begin
          band_d = '0;
          word_d = '0;
          gap_d  = '0;
        end else if (accept) begin
          w_data_d = s_data;
          w_addr_d = word_q;
          write_d  = BAND0_BIT << band_q;
          gap_d    = GAP_LOAD;
          if (word_q == LAST_WORD) begin
            word_d = '0;
            if (band_q == LAST_BAND) begin
              band_d  = '0;
              state_d = S_WAIT_SWAP;
            end else begin
              band_d = band_q + 1'b1;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_WAIT_SWAP: begin
        if (tick_edge) begin
          new_frame_d = 1'b1;
          state_d     = S_IDLE;
        end
        if (frame_start) begin
          err_restart_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_ready      = ready_c;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign write        = write_q;
  assign new_frame    = new_frame_q;
  assign err_restart  = err_restart_q;
  assign missed_ticks = missed_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/led_band_frame_loader.md
Name: led_band_frame_loader

Overview:
- Sequences the frame-memory write port of NB_BANDS led_band_controller instances from a single HPS word stream (valid/ready).
- Scatters each incoming W_DATA_WIDTH word to the correct band and address, then issues the broadcast new_frame buffer swap aligned to the next turn_tick rising edge.
- Sits between the HPS bridge and the led_band_controller write/new_frame inputs.

Parameters:
- NB_BANDS, 4, number of led_band_controller instances fed.
- W_DATA_WIDTH, 128, width of a write word.
- WORDS_PER_BAND, 768, words per band per frame (3*8*32*128/128).
- ADDR_WIDTH, $clog2(WORDS_PER_BAND), width of w_addr.
- WRITE_GAP, 1, idle cycles forced between two write strobes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: begin (or restart) loading a frame.
- s_data  in  W_DATA_WIDTH  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- turn_tick  in  1  rotation tick, already synchronous to clk, level held for many cycles.
- w_addr  out  ADDR_WIDTH  word address within the band.
- w_data  out  W_DATA_WIDTH  registered write data.
- write  out  NB_BANDS  one-hot write strobe, one bit per band.
- new_frame  out  1  one-cycle buffer-swap pulse, broadcast to all bands.
- busy  out  1  high in LOAD or WAIT_SWAP.
- err_restart  out  1  one-cycle pulse: frame_start seen in WAIT_SWAP.
- missed_ticks  out  8  saturating count of turn_tick rising edges seen during LOAD.

Behaviour:
- Reset: state IDLE; s_ready, write, new_frame, err_restart all 0; w_addr, w_data, missed_ticks all 0. The band and word counters reset to 0. The tick edge register reloads from the current turn_tick, so a tick held high through reset produces no edge.
- tick_edge = turn_tick && !turn_tick_q, where turn_tick_q is registered every cycle.
- States:
  - IDLE: on frame_start -> LOAD, with band=0 and word=0.
  - LOAD: s_ready = !frame_start && gap_cnt==0. On accept, next cycle: w_data=s_data, w_addr=word, write[band]=1 for exactly 1 cycle; gap_cnt loads WRITE_GAP.
    - gap_cnt decrements to 0 each cycle; with WRITE_GAP=0, back-to-back accepts are allowed.
    - word increments; at WORDS_PER_BAND-1 it wraps to 0 and band increments.
    - Order is band-major: all words of band 0, then band 1, and so on.
    - Accepting word WORDS_PER_BAND-1 of band NB_BANDS-1 moves the state to WAIT_SWAP; its write strobe still fires the next cycle.
  - LOAD with frame_start: band=0, word=0, gap_cnt=0, stay in LOAD. A strobe already registered from the previous cycle still fires.
  - LOAD with tick_edge: no swap; missed_ticks increments and saturates at 255.
  - WAIT_SWAP: s_ready=0. On tick_edge: new_frame=1 the next cycle for 1 cycle, then IDLE. If frame_start arrives, it is ignored and err_restart pulses the next cycle.
  - WAIT_SWAP, tick_edge and frame_start in the same cycle: the swap proceeds and err_restart also pulses.
- new_frame never coincides with any write bit, because the entry to WAIT_SWAP guarantees the final strobe has already fired.
- missed_ticks clears only on rst.
- busy = (state != IDLE), registered with the state.
- Data words past the end of a frame are not accepted; s_ready stays 0 outside LOAD.

Test Plan:
- Reset with turn_tick=1: after rst falls, no new_frame or missed_ticks change; all outputs 0 while rst=1.
- NB_BANDS=2, WORDS_PER_BAND=4, WRITE_GAP=1, frame_start then 8 words 0x10..0x17 with s_valid held high:
  - write strobes arrive every 2 cycles as write=01 at addr 0..3 (data 0x10..0x13), then write=10 at addr 0..3 (data 0x14..0x17);
  - busy=1, and the state reaches WAIT_SWAP after the 8th accept.
- Same load followed by a turn_tick rise 20 cycles later -> exactly one new_frame pulse 1 cycle after the edge, then busy=0 and s_ready=0.
- During LOAD: raise turn_tick 3 times -> missed_ticks=3 and no new_frame. Then pulse frame_start after word 5 and resend 8 words -> addresses restart at band 0, addr 0.
- In WAIT_SWAP, pulse frame_start -> err_restart=1 for 1 cycle and the state is unchanged. A following tick edge -> new_frame.
- WRITE_GAP=0, s_valid toggling 1/0 -> a strobe only for each accepted cycle, with no strobe lost or duplicated and 8 strobes total.
